// File: rtl/dmem_hs.sv
// Handshaked data memory with RISC-V B/H/W loads/stores and an error response.
// One request outstanding; the response appears LATENCY cycles after acceptance.
module dmem_hs #(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [2:0]           req_funct3,
  input  logic [WORD_LEN-1:0]  req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_LEN-1:0]  resp_rdata,
  output logic                 resp_err
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam logic [2:0]  LatCnt = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [WORD_LEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [WORD_LEN-1:0] mem_q [DEPTH];

  logic                accept, acc_err, wr_en;
  logic [IdxW-1:0]     idx;
  logic [1:0]          off;
  logic [WORD_LEN-1:0] rd_word, ld_data, wr_data;
  logic [3:0]          wr_be;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;

  assign req_ready = (state_q == StIdle) || ((state_q == StResp) && resp_ready);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[IdxW+1:2];
  assign off       = req_addr[1:0];
  assign rd_word   = mem_q[idx];
  assign byte_sel  = rd_word[{off, 3'b000} +: 8];
  assign half_sel  = rd_word[{off[1], 4'b0000} +: 16];

  always_comb begin : decode
    acc_err = 1'b0;
    ld_data = '0;
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    case (req_funct3)
      3'b000: begin
        ld_data = {{24{byte_sel[7]}}, byte_sel};
        wr_be   = 4'b0001 << off;
        wr_data = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        ld_data = {{16{half_sel[15]}}, half_sel};
        acc_err = off[0];
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        ld_data = rd_word;
        acc_err = (off != 2'b00);
        wr_be   = 4'b1111;
      end
      // Unsigned sizes exist only for loads.
      3'b100: begin
        ld_data = {24'b0, byte_sel};
        acc_err = req_we;
      end
      3'b101: begin
        ld_data = {16'b0, half_sel};
        acc_err = req_we || off[0];
      end
      default: acc_err = 1'b1;
    endcase
    if ((req_addr >> (IdxW + 2)) != '0) acc_err = 1'b1;
  end

  assign wr_en = accept && rstn && req_we && !acc_err;

  always_comb begin : next_state
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 3'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StResp:  if (resp_ready) state_d = StIdle;
      default: ;
    endcase
    // Accept only happens in IDLE or in a draining RESP, so it overrides the above.
    if (accept) begin
      state_d      = (LATENCY > 1) ? StWait : StResp;
      cnt_d        = LatCnt;
      resp_err_d   = acc_err;
      resp_rdata_d = (acc_err || req_we) ? '0 : ld_data;
    end
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Storage has no reset; contents survive rstn.
  always_ff @(posedge clk) begin : mem_write
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: two instances (LATENCY 1 and 4) checked every cycle against a
// byte-level, time-based reference model, plus directed literal expectations.
module tb_dmem_hs;

  localparam int unsigned Depth = 1024;

  logic             clk;
  logic             rstn;
  logic [1:0]       rv, we, rr;
  logic [1:0][31:0] addr, wd;
  logic [1:0][2:0]  f3;
  logic [1:0]       rdy, vld, err_o;
  logic [1:0][31:0] rd;

  int checks = 0;
  int errors = 0;

  dmem_hs #(.WORD_LEN(32), .ADDR_SIZE(32), .DEPTH(Depth), .LATENCY(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_funct3(f3[0]), .req_wdata(wd[0]), .resp_valid(vld[0]),
    .resp_ready(rr[0]), .resp_rdata(rd[0]), .resp_err(err_o[0])
  );

  dmem_hs #(.WORD_LEN(32), .ADDR_SIZE(32), .DEPTH(Depth), .LATENCY(4)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_funct3(f3[1]), .req_wdata(wd[1]), .resp_valid(vld[1]),
    .resp_ready(rr[1]), .resp_rdata(rd[1]), .resp_err(err_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte memory per instance, one pending response with a due cycle.
  logic [7:0]  mm [bit [32:0]];
  int          cyc = 0;
  bit   [1:0]  pend = 2'b00;
  int          due [2];
  logic [31:0] erd [2];
  bit          eerr [2];
  bit          started = 1'b0;
  bit          vb, rb, cv, cr, tmp_er;
  logic [31:0] tmp_rd;

  function automatic void mdl_access(input bit kk, input bit w, input logic [31:0] a,
                                     input logic [2:0] f, input logic [31:0] d,
                                     output logic [31:0] r, output bit er);
    int sz;
    bit uns;
    logic [31:0] v;
    r = 32'h0; er = 1'b0; v = 32'h0; sz = 1; uns = 1'b0;
    case (f)
      3'b000: sz = 1;
      3'b001: sz = 2;
      3'b010: sz = 4;
      3'b100: begin sz = 1; uns = 1'b1; end
      3'b101: begin sz = 2; uns = 1'b1; end
      default: er = 1'b1;
    endcase
    if ((a % sz) != 0) er = 1'b1;
    if (a >= Depth * 4) er = 1'b1;
    if (w && uns) er = 1'b1;
    if (er) return;
    for (int i = 0; i < sz; i++) begin
      if (w) mm[{kk, 32'(a + 32'(i))}] = d[8*i +: 8];
      else   v[8*i +: 8] = mm[{kk, 32'(a + 32'(i))}];
    end
    if (!w) begin
      r = v;
      for (int j = 8 * sz; j < 32; j++) r[j] = uns ? 1'b0 : v[8*sz-1];
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      vb = pend[k] && (cyc >= due[k]);
      rb = !pend[k] || (vb && rr[k]);
      if (!rstn) begin
        pend[k] = 1'b0;
      end else begin
        if (vb && rr[k]) pend[k] = 1'b0;
        if (rv[k] && rb) begin
          mdl_access(k[0], we[k], addr[k], f3[k], wd[k], tmp_rd, tmp_er);
          erd[k]  = tmp_rd;
          eerr[k] = tmp_er;
          pend[k] = 1'b1;
          due[k]  = cyc + lat(k);
        end
      end
    end
    cyc = cyc + 1;
    if (!rstn) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        cv = pend[k] && (cyc >= due[k]);
        cr = !pend[k] || (cv && rr[k]);
        lit($sformatf("mdl_dut%0d_resp_valid", k), 32'(vld[k]), 32'(cv));
        lit($sformatf("mdl_dut%0d_req_ready", k), 32'(rdy[k]), 32'(cr));
        if (cv) begin
          lit($sformatf("mdl_dut%0d_rdata", k), rd[k], erd[k]);
          lit($sformatf("mdl_dut%0d_err", k), 32'(err_o[k]), 32'(eerr[k]));
        end
      end
    end
  end

  task automatic send(input int k, input bit w, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] d);
    bit done;
    done = 1'b0;
    we[k] = w; addr[k] = a; f3[k] = f; wd[k] = d; rv[k] = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (rdy[k]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    rv[k] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d addr %h got no req_ready want req_ready", k, a);
    end
  endtask

  task automatic expect_resp(input int k, input logic [31:0] exp_rd, input bit exp_err,
                             input string nm);
    int waited;
    bit seen;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      if (vld[k]) seen = 1'b1;
      else        waited++;
    end
    lit({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      lit({nm, "_lat"}, 32'(waited), 32'(lat(k) - 1));
      lit({nm, "_rdata"}, rd[k], exp_rd);
      lit({nm, "_err"}, 32'(err_o[k]), 32'(exp_err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; rv = '0; we = '0; rr = 2'b11; addr = '0; wd = '0; f3 = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      lit($sformatf("reset_dut%0d_req_ready", k), 32'(rdy[k]), 32'd1);
      lit($sformatf("reset_dut%0d_resp_valid", k), 32'(vld[k]), 32'd0);
      lit($sformatf("reset_dut%0d_rdata", k), rd[k], 32'h0);
      lit($sformatf("reset_dut%0d_err", k), 32'(err_o[k]), 32'd0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;

    // LATENCY=1: store then back-to-back load.
    send(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    send(0, 1'b0, 32'h10, 3'b010, 32'h0);
    expect_resp(0, 32'hDEADBEEF, 1'b0, "lw_10");
    send(0, 1'b0, 32'h13, 3'b000, 32'h0); expect_resp(0, 32'hFFFFFFDE, 1'b0, "lb_13");
    send(0, 1'b0, 32'h13, 3'b100, 32'h0); expect_resp(0, 32'h000000DE, 1'b0, "lbu_13");
    send(0, 1'b0, 32'h12, 3'b001, 32'h0); expect_resp(0, 32'hFFFFDEAD, 1'b0, "lh_12");
    send(0, 1'b0, 32'h12, 3'b101, 32'h0); expect_resp(0, 32'h0000DEAD, 1'b0, "lhu_12");
    send(0, 1'b1, 32'h11, 3'b000, 32'hAAAAAA55); expect_resp(0, 32'h0, 1'b0, "sb_11");
    send(0, 1'b0, 32'h10, 3'b010, 32'h0); expect_resp(0, 32'hDEAD55EF, 1'b0, "lw_after_sb");
    send(0, 1'b1, 32'h12, 3'b001, 32'hBBBB1234); expect_resp(0, 32'h0, 1'b0, "sh_12");
    send(0, 1'b0, 32'h10, 3'b010, 32'h0); expect_resp(0, 32'h123455EF, 1'b0, "lw_after_sh");
    send(0, 1'b0, 32'h10, 3'b001, 32'h0); expect_resp(0, 32'h000055EF, 1'b0, "lh_10_pos");

    // Faults: no side effect, zero data.
    send(0, 1'b0, 32'h12, 3'b010, 32'h0); expect_resp(0, 32'h0, 1'b1, "lw_misaligned");
    send(0, 1'b1, 32'h11, 3'b001, 32'hFFFF); expect_resp(0, 32'h0, 1'b1, "sh_misaligned");
    send(0, 1'b0, 32'h10, 3'b011, 32'h0); expect_resp(0, 32'h0, 1'b1, "funct3_011");
    send(0, 1'b1, Depth * 4, 3'b000, 32'h77); expect_resp(0, 32'h0, 1'b1, "sb_out_of_range");
    send(0, 1'b1, 32'h10, 3'b100, 32'h77); expect_resp(0, 32'h0, 1'b1, "store_bu");
    send(0, 1'b0, 32'h10, 3'b010, 32'h0); expect_resp(0, 32'h123455EF, 1'b0, "lw_unchanged");

    // LATENCY=4 with a stalled consumer and a second request waiting.
    send(1, 1'b1, 32'h10, 3'b010, 32'h11223344); expect_resp(1, 32'h0, 1'b0, "l4_sw");
    rr[1] = 1'b0;
    send(1, 1'b0, 32'h10, 3'b010, 32'h0);
    we[1] = 1'b1; addr[1] = 32'h14; f3[1] = 3'b010; wd[1] = 32'hCAFEF00D; rv[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lit($sformatf("stall_valid_%0d", i), 32'(vld[1]), (i >= 3) ? 32'd1 : 32'd0);
      lit($sformatf("stall_ready_%0d", i), 32'(rdy[1]), 32'd0);
      if (i >= 3) lit($sformatf("stall_rdata_%0d", i), rd[1], 32'h11223344);
      @(posedge clk);
      #1;
    end
    rr[1] = 1'b1;
    @(negedge clk);
    lit("stall_release_ready", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    #1 rv[1] = 1'b0;
    expect_resp(1, 32'h0, 1'b0, "l4_second_sw");
    send(1, 1'b0, 32'h14, 3'b010, 32'h0); expect_resp(1, 32'hCAFEF00D, 1'b0, "l4_lw_14");

    // Reset while in WAIT; a request presented during reset must be ignored.
    send(1, 1'b1, 32'h20, 3'b010, 32'hA5A5A5A5);
    rstn = 1'b0;
    we[1] = 1'b1; addr[1] = 32'h20; f3[1] = 3'b010; wd[1] = 32'hFFFFFFFF; rv[1] = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rv[1] = 1'b0;
    @(negedge clk);
    lit("rst_wait_resp_valid", 32'(vld[1]), 32'd0);
    lit("rst_wait_req_ready", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    #1;
    send(1, 1'b0, 32'h20, 3'b010, 32'h0); expect_resp(1, 32'hA5A5A5A5, 1'b0, "lw_20_after_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_hs.md
# dmem_hs

Handshaked, parametrised data memory that replaces the combinational-read data memory on the CPU's load/store path. It accepts one load or store request at a time over a valid/ready channel. It performs RISC-V byte/half/word access with sign or zero extension. It returns a response, including an error flag for misaligned, out-of-range or illegal accesses, after a configurable latency.

## Interface
- `WORD_LEN`, 32, data word width in bits; must be 32.
- `ADDR_SIZE`, 32, byte-address width.
- `DEPTH`, 1024, number of words; a power of two, 2 to 2^(ADDR_SIZE-2).
- `LATENCY`, 1, cycles from request acceptance to first `resp_valid`; legal range 1..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_SIZE  byte address.
- `req_funct3`  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_wdata`  in  WORD_LEN  store data, taken from the low bits.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  WORD_LEN  load result, extended; 0 for stores and errors.
- `resp_err`  out  1  access faulted; no memory side effect occurred.

## Operation
- Storage is `DEPTH` x `WORD_LEN`, indexed by `req_addr[log2(DEPTH)+1:2]`. The byte offset is `req_addr[1:0]`. Storage is never cleared by reset.
- Acceptance: a request is accepted on an edge where `req_valid && req_ready`. All request fields are sampled on that edge.
- Errors are evaluated on the accept edge. Any error sets `resp_err=1` and `resp_rdata=0`, and no write occurs. The error conditions are:
  - misaligned: H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
  - out of range: `req_addr[ADDR_SIZE-1:log2(DEPTH)+2]` is non-zero.
  - illegal: funct3 is 011, 110 or 111.
  - store with BU or HU funct3.
- Stores commit on the accept edge. B writes byte lane `addr[1:0]` with `wdata[7:0]`. H writes lane `addr[1]` with `wdata[15:0]`. W writes the whole word. Other lanes are unchanged.
- Loads read the addressed word on the accept edge, so a store accepted earlier is visible. The selected lane is placed in `resp_rdata`:
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: the full word.
- Loads return data; stores return a response with `resp_rdata=0`.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: `req_ready=1`. On accept, go to WAIT if `LATENCY>1`, otherwise go to RESP.
  - WAIT: a countdown counter loads `LATENCY-2` on entry. Go to RESP when it reaches 0.
  - RESP: `resp_valid=1`. `resp_rdata` and `resp_err` are held stable until `resp_ready`.
  - In RESP with `resp_ready`, `req_ready=1`. If a request is accepted that cycle, go to WAIT or RESP as above; otherwise go to IDLE.
- At most one request is outstanding. `req_ready=0` in WAIT, and in RESP while `resp_ready=0`.
- Reset (`rstn=0` at an edge):
  - state goes to IDLE.
  - the counter clears.
  - the pending response is dropped.
  - a store already committed stays committed.
  - a request presented in the reset cycle is not accepted.

## Timing
- Reset values: `req_ready=1` (IDLE), `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
- Accept at edge N gives `resp_valid=1` in the cycle after edge N+LATENCY-1. With `LATENCY=1`, this is the cycle immediately after accept.
- `req_ready` is a function of state and `resp_ready` only; it does not depend on `req_valid`.
- `resp_valid` is registered (driven from state).
- Back-to-back throughput with `resp_ready=1` is one request per `LATENCY` cycles.
- All outputs are driven from registers, except that `req_ready` uses combinational `resp_ready` in RESP.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 (`LATENCY=1`, `resp_ready=1`) -> two responses on consecutive cycles. The LW response has `resp_rdata=0xDEADBEEF`, `resp_err=0`.
- After that word, load 0x13 with LB, LBU, LH @0x12 and LHU @0x12 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD respectively.
- SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF. SH 0x1234 @0x12 then LW @0x10 -> 0x123455EF.
- Fault cases, each giving `resp_err=1` and `resp_rdata=0` with the word at 0x10 left unchanged:
  - LW @0x12
  - SH @0x11
  - funct3=011
  - SB with addr = DEPTH*4
- `LATENCY=4`, `resp_ready` held low 3 cycles:
  - `resp_valid` rises 4 cycles after accept and is held stable.
  - `req_ready=0` throughout WAIT and the stalled RESP.
  - a second request waits.
- Reset during WAIT after an accepted SW 0xA5A5A5A5 @0x20 -> no `resp_valid` and `req_ready=1` next cycle. A subsequent LW @0x20 returns 0xA5A5A5A5.
